// File: rtl/fetch_unit_if.sv
// Signal bundle for fetch_unit: instruction-memory read port, PC redirect
// input, and the instruction output channel toward the opcode decoder.
interface fetch_unit_if #(
   parameter int ADDR_W  = 8,
   parameter int INSTR_W = 16
);
   logic               imem_req;
   logic [ADDR_W-1:0]  imem_addr;
   logic               imem_ack;
   logic [INSTR_W-1:0] imem_rdata;
   logic               redirect_valid;
   logic [ADDR_W-1:0]  redirect_pc;
   logic               out_valid;
   logic               out_ready;
   logic [INSTR_W-1:0] out_instr;
   logic [3:0]         out_opcode;
   logic [ADDR_W-1:0]  out_pc;

   // Output handshake: an instruction transfers on every rising edge where
   // out_valid and out_ready are both 1. Once out_valid rises, out_instr and
   // out_pc hold unchanged until that transfer (or a redirect) withdraws them;
   // out_ready may change freely and never depends combinationally on out_valid.

   modport master (
      output imem_req, imem_addr, out_valid, out_instr, out_opcode, out_pc,
      input  imem_ack, imem_rdata, redirect_valid, redirect_pc, out_ready
   );

   modport slave (
      input  imem_req, imem_addr, out_valid, out_instr, out_opcode, out_pc,
      output imem_ack, imem_rdata, redirect_valid, redirect_pc, out_ready
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem reads, instruction register.
// Optional macro FETCH_HALT_EN adds a HALT state entered after accepting opcode 4'b1111.
module fetch_unit #(
   parameter int                ADDR_W   = 8,
   parameter int                INSTR_W  = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             reset,
   fetch_unit_if.master     bus,
   output logic [2:0]       dbg_state
);

   typedef enum logic [2:0] {
      S_REQ  = 3'd0,
      S_WAIT = 3'd1,
      S_HOLD = 3'd2,
      S_DROP = 3'd3
`ifdef FETCH_HALT_EN
      ,
      S_HALT = 3'd4
`endif
   } state_t;

   state_t            state;
   state_t            nxt_state;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] nxt_pc;
   logic              nxt_valid;
   logic              load_instr;

   assign dbg_state      = state;
   assign bus.out_opcode = bus.out_instr[INSTR_W-1 -: 4];

   always_comb begin
      nxt_state  = state;
      nxt_pc     = pc;
      nxt_valid  = bus.out_valid;
      load_instr = 1'b0;

      case (state)
         // REQ with imem_req low only happens right after reset: issue next cycle.
         S_REQ: begin
            if (bus.imem_req) nxt_state = S_WAIT;
         end
         S_WAIT: begin
            if (bus.imem_ack) begin
               load_instr = 1'b1;
               nxt_valid  = 1'b1;
               nxt_pc     = pc + ADDR_W'(1);
               nxt_state  = S_HOLD;
            end
         end
         S_HOLD: begin
            if (bus.out_ready) begin
               nxt_valid = 1'b0;
               nxt_state = S_REQ;
`ifdef FETCH_HALT_EN
               if (bus.out_instr[INSTR_W-1 -: 4] == 4'hF) nxt_state = S_HALT;
`endif
            end
         end
         S_DROP: begin
            if (bus.imem_ack) nxt_state = S_REQ;
         end
         default: nxt_state = state;
      endcase

      // Redirect overrides everything; a request already in flight must drain in DROP.
      if (bus.redirect_valid) begin
         nxt_pc     = bus.redirect_pc;
         nxt_valid  = 1'b0;
         load_instr = 1'b0;
         case (state)
            S_REQ:   nxt_state = bus.imem_req ? S_DROP : S_REQ;
            S_WAIT:  nxt_state = bus.imem_ack ? S_REQ : S_DROP;
            // An ack arriving with the redirect still retires the old request.
            S_DROP:  nxt_state = bus.imem_ack ? S_REQ : S_DROP;
            default: nxt_state = S_REQ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= S_REQ;
         pc            <= RESET_PC;
         bus.imem_req  <= 1'b0;
         bus.imem_addr <= '0;
         bus.out_valid <= 1'b0;
         bus.out_instr <= '0;
         bus.out_pc    <= '0;
      end else begin
         state         <= nxt_state;
         pc            <= nxt_pc;
         bus.out_valid <= nxt_valid;
         // imem_req is high exactly for the cycle spent in REQ after issuing.
         bus.imem_req  <= (nxt_state == S_REQ);
         if (nxt_state == S_REQ) bus.imem_addr <= nxt_pc;
         if (load_instr) begin
            bus.out_instr <= bus.imem_rdata;
            bus.out_pc    <= pc;
         end
      end
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the opcode decoder.
- Holds the program counter (PC) and issues single-outstanding read requests to instruction memory.
- Latches each returned word into an instruction register and presents it with a valid/ready handshake; out_opcode drives the decoder's 4-bit opcode input.
- Supports PC redirect (branch/jump) with squash of in-flight fetches.

Parameters:
- ADDR_W, 8, PC / instruction-memory address width.
- INSTR_W, 16, instruction width; opcode is instr[INSTR_W-1 -: 4].
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- imem_req  output  1  read request strobe, asserted exactly one cycle per fetch.
- imem_addr  output  ADDR_W  fetch address, valid while imem_req=1.
- imem_ack  input  1  read data valid pulse from instruction memory.
- imem_rdata  input  INSTR_W  read data, sampled when imem_ack=1.
- redirect_valid  input  1  one-cycle pulse: load new PC, squash current fetch.
- redirect_pc  input  ADDR_W  redirect target.
- out_valid  output  1  instruction register holds a valid instruction.
- out_ready  input  1  downstream accepts instruction when out_valid & out_ready.
- out_instr  output  INSTR_W  instruction register.
- out_opcode  output  4  out_instr[INSTR_W-1 -: 4], to decoder opcode.
- out_pc  output  ADDR_W  address of out_instr.

Behaviour:
- Reset (clk edge with reset=1):
  - pc=RESET_PC, state=REQ.
  - imem_req=0, out_valid=0, out_instr=0, out_pc=0.
  - Reset overrides everything, including mid-fetch; a late imem_ack after reset is ignored until the next request.
- States REQ, WAIT, HOLD, DROP. All outputs registered.
- REQ:
  - imem_req=1, imem_addr=pc for exactly one cycle, then -> WAIT.
- WAIT:
  - imem_ack sampled here only (earliest one cycle after imem_req).
  - On ack: out_instr<=imem_rdata, out_pc<=pc, out_valid<=1, pc<=pc+1 (mod 2^ADDR_W; 2^ADDR_W-1 wraps to 0), -> HOLD.
  - Without ack: stay; no timeout.
- HOLD:
  - out_valid=1; out_instr/out_pc stable until handshake.
  - On out_valid & out_ready: out_valid<=0, -> REQ. Next request is issued the cycle after the handshake.
- DROP:
  - Wait for imem_ack, discard imem_rdata, -> REQ.
- Latency: imem_req at cycle t; ack at t+k (k>=1); out_valid at t+k+1. Minimum 3 cycles per instruction with out_ready held at 1.
- Redirect has priority over every other event in the same cycle:
  - pc<=redirect_pc and out_valid<=0, even if a handshake occurs that cycle; the handshake still counts as accepted.
  - From REQ, or WAIT without ack: -> DROP (one request outstanding).
  - WAIT with ack in the same cycle: data discarded, -> REQ.
  - From HOLD: -> REQ.
  - From DROP: stay in DROP, pc updated.
- Never more than one outstanding imem request.

Optional Feature:
- Macro FETCH_HALT_EN.
- When defined:
  - Adds state HALT. A fetched word with opcode 4'b1111 is presented normally in HOLD.
  - After its handshake the unit enters HALT instead of REQ: imem_req=0, out_valid=0.
  - HALT exits only on redirect (-> REQ at redirect_pc) or reset.
- When undefined: opcode 4'b1111 is treated like any other opcode; no HALT state exists.

Test Plan:
- Reset with RESET_PC=0, memory ack after 1 cycle, out_ready=1 -> imem_addr sequence 0,1,2; out_pc 0,1,2; out_opcode = rdata[15:12]; first out_valid 3 cycles after reset release.
- out_ready=0 for 5 cycles with word 16'h2ABC latched -> out_valid and out_instr=16'h2ABC stable for 5 cycles, imem_req=0 throughout; next fetch issues the cycle after out_ready rises.
- redirect_valid with redirect_pc=8'h40 during WAIT, ack 2 cycles later with 16'h1111 -> 16'h1111 never presented; next imem_addr=8'h40.
- redirect on the same cycle as imem_ack -> data dropped; imem_req for redirect_pc on the next cycle.
- PC=8'hFF fetched and accepted -> next imem_addr=8'h00.
- With FETCH_HALT_EN, word 16'hF000 accepted -> imem_req stays 0 for 10 cycles; redirect to 8'h10 -> imem_addr=8'h10 next cycle. Without the macro -> fetch continues at the next PC.
